alu_issue: RTL and testbench

Sequential front end for the combinational ALU. It accepts one RV32I integer instruction (OP or OP-IMM) over a valid/ready handshake and decodes it into `func3`/`func7`. It fetches operands from an internal 32-entry register file, drives the ALU, captures `alu_rd_data` and writes it back to `rd`. Execution is strictly serial: one instruction in flight, so there are no hazards.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_issue_if.sv | 30 +++
 rtl/alu_issue_regfile.sv | 36 +++
 rtl/alu_issue.sv | 163 ++++++++++++++++
 tb/tb_alu_issue.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants, ALU operation encodings and FSM state type for the
// ALU issue front end.
package alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // {func7, func3} encodings understood by the ALU
    localparam logic [9:0] ALU_ADD  = {F7_BASE, 3'b000};
    localparam logic [9:0] ALU_SUB  = {F7_ALT,  3'b000};
    localparam logic [9:0] ALU_SLL  = {F7_BASE, 3'b001};
    localparam logic [9:0] ALU_SLT  = {F7_BASE, 3'b010};
    localparam logic [9:0] ALU_SLTU = {F7_BASE, 3'b011};
    localparam logic [9:0] ALU_XOR  = {F7_BASE, 3'b100};
    localparam logic [9:0] ALU_SRL  = {F7_BASE, 3'b101};
    localparam logic [9:0] ALU_SRA  = {F7_ALT,  3'b101};
    localparam logic [9:0] ALU_OR   = {F7_BASE, 3'b110};
    localparam logic [9:0] ALU_AND  = {F7_BASE, 3'b111};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } issue_state_t;

    function automatic logic alu_op_legal(input logic [6:0] f7, input logic [2:0] f3);
        logic ok;
        case ({f7, f3})
            ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
            ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: ok = 1'b1;
            default:                                    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake, ALU drive/return and writeback report bundle.
interface alu_issue_if #(parameter int DATA_WIDTH = 32) ();

    logic                  instr_valid;
    logic                  instr_ready;
    logic [31:0]           instr;
    logic [2:0]            func3;
    logic [6:0]            func7;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] alu_rd_data;
    logic                  wb_valid;
    logic [4:0]            wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  illegal;

    // Environment side: instruction source plus the combinational ALU
    modport master (
        output instr_valid, instr, alu_rd_data,
        input  instr_ready, func3, func7, rs1_data, rs2_data,
               wb_valid, wb_addr, wb_data, illegal
    );

    modport slave (
        input  instr_valid, instr, alu_rd_data,
        output instr_ready, func3, func7, rs1_data, rs2_data,
               wb_valid, wb_addr, wb_data, illegal
    );

endinterface

// File: rtl/alu_issue_regfile.sv
// 32-entry integer register file: two operand reads, one write, one debug
// read; x0 always reads zero and ignores writes.
module regfile #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    input  logic [4:0]            dbg_addr,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    logic [DATA_WIDTH-1:0] regs_r [32];

    // Register storage with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs_r[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs_r[rs2_addr];
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_r[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Serial issue unit: decodes one RV32I OP/OP-IMM instruction, presents
// operands to the external ALU for one cycle, then writes the result back.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_issue_if.slave            bus,
    input  logic [4:0]            dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    issue_state_t state_r;
    issue_state_t state_next_s;

    logic                  fire_s;
    logic                  legal_s;
    logic [2:0]            dec_func3_s;
    logic [6:0]            dec_func7_s;
    logic [DATA_WIDTH-1:0] dec_b_s;
    logic [DATA_WIDTH-1:0] imm_sext_s;
    logic [DATA_WIDTH-1:0] shamt_s;
    logic [DATA_WIDTH-1:0] rf_rs1_s;
    logic [DATA_WIDTH-1:0] rf_rs2_s;
    logic                  rf_we_s;

    logic                  ready_r;
    logic [2:0]            func3_r;
    logic [6:0]            func7_r;
    logic [DATA_WIDTH-1:0] rs1_data_r;
    logic [DATA_WIDTH-1:0] rs2_data_r;
    logic [4:0]            rd_r;
    logic                  wb_valid_r;
    logic [4:0]            wb_addr_r;
    logic [DATA_WIDTH-1:0] wb_data_r;
    logic                  illegal_r;

    assign fire_s     = bus.instr_valid && ready_r;
    assign imm_sext_s = {{(DATA_WIDTH-12){bus.instr[31]}}, bus.instr[31:20]};
    assign shamt_s    = {{(DATA_WIDTH-5){1'b0}}, bus.instr[24:20]};

    // A reset landing on the WB cycle must not commit the dropped result
    assign rf_we_s = wb_valid_r && !rst;

    regfile #(.DATA_WIDTH(DATA_WIDTH)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (bus.instr[19:15]),
        .rs2_addr (bus.instr[24:20]),
        .dbg_addr (dbg_addr),
        .we       (rf_we_s),
        .waddr    (wb_addr_r),
        .wdata    (wb_data_r),
        .rs1_data (rf_rs1_s),
        .rs2_data (rf_rs2_s),
        .dbg_data (dbg_data)
    );

    // Instruction decode: legality, ALU function fields and operand B select
    always_comb begin
        legal_s     = 1'b0;
        dec_func3_s = bus.instr[14:12];
        dec_func7_s = F7_BASE;
        dec_b_s     = rf_rs2_s;
        case (bus.instr[6:0])
            OPC_OP: begin
                dec_func7_s = bus.instr[31:25];
                legal_s     = alu_op_legal(bus.instr[31:25], bus.instr[14:12]);
            end
            OPC_OP_IMM: begin
                if (bus.instr[14:12] == 3'b001) begin
                    dec_b_s = shamt_s;
                    legal_s = (bus.instr[31:25] == F7_BASE);
                end else if (bus.instr[14:12] == 3'b101) begin
                    dec_b_s = shamt_s;
                    if (bus.instr[30]) begin
                        dec_func7_s = F7_ALT;
                        legal_s     = (bus.instr[31:25] == F7_ALT);
                    end else begin
                        legal_s     = (bus.instr[31:25] == F7_BASE);
                    end
                end else begin
                    // bit 30 of an ADDI immediate is data, never a SUB select
                    dec_b_s = imm_sext_s;
                    legal_s = 1'b1;
                end
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fire_s && legal_s) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: state_next_s = ST_WB;
            ST_WB:   state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Registered handshake, ALU drive and writeback outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r    <= 1'b0;
            func3_r    <= 3'd0;
            func7_r    <= 7'd0;
            rs1_data_r <= '0;
            rs2_data_r <= '0;
            rd_r       <= 5'd0;
            wb_valid_r <= 1'b0;
            wb_addr_r  <= 5'd0;
            wb_data_r  <= '0;
            illegal_r  <= 1'b0;
        end else begin
            ready_r    <= (state_next_s == ST_IDLE);
            illegal_r  <= fire_s && !legal_s;
            wb_valid_r <= (state_r == ST_EXEC);
            if (fire_s && legal_s) begin
                func3_r    <= dec_func3_s;
                func7_r    <= dec_func7_s;
                rs1_data_r <= rf_rs1_s;
                rs2_data_r <= dec_b_s;
                rd_r       <= bus.instr[11:7];
            end
            if (state_r == ST_EXEC) begin
                wb_addr_r <= rd_r;
                wb_data_r <= bus.alu_rd_data;
            end
        end
    end

    assign bus.instr_ready = ready_r;
    assign bus.func3       = func3_r;
    assign bus.func7       = func7_r;
    assign bus.rs1_data    = rs1_data_r;
    assign bus.rs2_data    = rs2_data_r;
    assign bus.wb_valid    = wb_valid_r;
    assign bus.wb_addr     = wb_addr_r;
    assign bus.wb_data     = wb_data_r;
    assign bus.illegal     = illegal_r;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed vector table, random
// instructions against a mnemonic-level reference model, and timing corners.
module tb_alu_issue;
    import alu_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    dbg_addr = 5'd0;
    logic [DW-1:0] dbg_data;

    alu_issue_if #(.DATA_WIDTH(DW)) bus ();

    alu_issue #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [31:0] shadow [32];

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the combinational ALU
    always_comb begin
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = bus.rs1_data;
        sb = bus.rs2_data;
        case ({bus.func7, bus.func3})
            ALU_ADD:  bus.alu_rd_data = bus.rs1_data + bus.rs2_data;
            ALU_SUB:  bus.alu_rd_data = bus.rs1_data - bus.rs2_data;
            ALU_SLL:  bus.alu_rd_data = bus.rs1_data << bus.rs2_data[4:0];
            ALU_SLT:  bus.alu_rd_data = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: bus.alu_rd_data = (bus.rs1_data < bus.rs2_data) ? 32'd1 : 32'd0;
            ALU_XOR:  bus.alu_rd_data = bus.rs1_data ^ bus.rs2_data;
            ALU_SRL:  bus.alu_rd_data = bus.rs1_data >> bus.rs2_data[4:0];
            ALU_SRA:  bus.alu_rd_data = sa >>> bus.rs2_data[4:0];
            ALU_OR:   bus.alu_rd_data = bus.rs1_data | bus.rs2_data;
            ALU_AND:  bus.alu_rd_data = bus.rs1_data & bus.rs2_data;
            default:  bus.alu_rd_data = 32'hDEAD_BEEF;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: instruction semantics by mnemonic on the architectural state
    function automatic void ref_model(input logic [31:0] ins, output logic legal,
                                      output logic [2:0] f3, output logic [6:0] f7,
                                      output logic [31:0] b, output logic [31:0] res);
        logic [31:0]        a;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               alt;
        a     = shadow[ins[19:15]];
        f3    = ins[14:12];
        f7    = 7'd0;
        b     = 32'd0;
        legal = 1'b0;
        alt   = 1'b0;
        if (ins[6:0] == 7'h33) begin
            b     = shadow[ins[24:20]];
            f7    = ins[31:25];
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            alt   = (f7 == 7'h20);
        end else if (ins[6:0] == 7'h13) begin
            b     = {{20{ins[31]}}, ins[31:20]};
            legal = 1'b1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
                b     = {27'd0, ins[24:20]};
                legal = (ins[31:25] == 7'h00) || (f3 == 3'd5 && ins[31:25] == 7'h20);
                alt   = (f3 == 3'd5) && ins[30];
                f7    = alt ? 7'h20 : 7'h00;
            end
        end
        sa = a;
        sb = b;
        case (f3)
            3'd0: res = alt ? a - b : a + b;
            3'd1: res = a << b[4:0];
            3'd2: res = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd5: if (alt) res = sa >>> b[4:0]; else res = a >> b[4:0];
            3'd6: res = a | b;
            default: res = a & b;
        endcase
    endfunction

    // Issue one instruction from an IDLE cycle (#1 after posedge) and check every phase
    task automatic run_instr(input string name, input logic [31:0] ins, input logic exp_legal,
                             input logic [2:0] ef3, input logic [6:0] ef7,
                             input logic [31:0] eb, input logic [31:0] eres);
        logic [4:0]  rd;
        logic [31:0] ea;
        rd = ins[11:7];
        ea = shadow[ins[19:15]];
        chk({name, " ready_idle"}, bus.instr_ready, 32'd1);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        if (exp_legal) begin
            chk({name, " illegal"},    bus.illegal,     32'd0);
            chk({name, " wb_early"},   bus.wb_valid,    32'd0);
            chk({name, " ready_exec"}, bus.instr_ready, 32'd0);
            chk({name, " func3"},      bus.func3,       ef3);
            chk({name, " func7"},      bus.func7,       ef7);
            chk({name, " rs1_data"},   bus.rs1_data,    ea);
            chk({name, " rs2_data"},   bus.rs2_data,    eb);
            @(posedge clk); #1;
            chk({name, " wb_valid"},   bus.wb_valid,    32'd1);
            chk({name, " wb_addr"},    bus.wb_addr,     rd);
            chk({name, " wb_data"},    bus.wb_data,     eres);
            if (rd != 5'd0) shadow[rd] = eres;
            @(posedge clk); #1;
            chk({name, " wb_pulse"},   bus.wb_valid,    32'd0);
            chk({name, " ready_back"}, bus.instr_ready, 32'd1);
        end else begin
            chk({name, " illegal"},    bus.illegal,     32'd1);
            chk({name, " wb_none"},    bus.wb_valid,    32'd0);
            chk({name, " ready_ill"},  bus.instr_ready, 32'd1);
            @(posedge clk); #1;
            chk({name, " ill_pulse"},  bus.illegal,     32'd0);
            chk({name, " wb_none2"},   bus.wb_valid,    32'd0);
        end
        dbg_addr = rd;
        #1;
        chk({name, " dbg_rd"}, dbg_data, shadow[rd]);
    endtask

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic        legal;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    vec_t vecs [15];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic        m_legal;
        logic [2:0]  m_f3;
        logic [6:0]  m_f7;
        logic [31:0] m_b;
        logic [31:0] m_res;
        logic [31:0] r;
        logic [31:0] ins;
        logic [31:0] seq [3];
        int          acc [3];
        int          n;
        int          kind;

        vecs[0]  = '{"addi_m5",    32'hFFB00093, 1'b1, 3'd0, 7'h00, 32'hFFFFFFFB, 32'hFFFFFFFB};
        vecs[1]  = '{"addi_1",     32'h00100093, 1'b1, 3'd0, 7'h00, 32'h00000001, 32'h00000001};
        vecs[2]  = '{"slli_31",    32'h01F09093, 1'b1, 3'd1, 7'h00, 32'h0000001F, 32'h80000000};
        vecs[3]  = '{"srai_4",     32'h4040D113, 1'b1, 3'd5, 7'h20, 32'h00000004, 32'hF8000000};
        vecs[4]  = '{"addi_7",     32'h00700093, 1'b1, 3'd0, 7'h00, 32'h00000007, 32'h00000007};
        vecs[5]  = '{"addi_3",     32'h00300113, 1'b1, 3'd0, 7'h00, 32'h00000003, 32'h00000003};
        vecs[6]  = '{"sub",        32'h402081B3, 1'b1, 3'd0, 7'h20, 32'h00000003, 32'h00000004};
        vecs[7]  = '{"add_x0",     32'h00208033, 1'b1, 3'd0, 7'h00, 32'h00000003, 32'h0000000A};
        vecs[8]  = '{"jal",        32'h0000006F, 1'b0, 3'd0, 7'h00, 32'h0,        32'h0};
        vecs[9]  = '{"r_bad_f7",   32'h4020C1B3, 1'b0, 3'd0, 7'h00, 32'h0,        32'h0};
        vecs[10] = '{"slli_bad",   32'h02109093, 1'b0, 3'd0, 7'h00, 32'h0,        32'h0};
        vecs[11] = '{"addi_b30",   32'h40008313, 1'b1, 3'd0, 7'h00, 32'h00000400, 32'h00000407};
        vecs[12] = '{"srli_1",     32'h0010D393, 1'b1, 3'd5, 7'h00, 32'h00000001, 32'h00000003};
        vecs[13] = '{"srai_bad",   32'h6040D113, 1'b0, 3'd0, 7'h00, 32'h0,        32'h0};
        vecs[14] = '{"sltiu_m1",   32'hFFF0B493, 1'b1, 3'd3, 7'h00, 32'hFFFFFFFF, 32'h00000001};

        for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst ready",    bus.instr_ready, 32'd0);
        chk("rst wb_valid", bus.wb_valid,    32'd0);
        chk("rst illegal",  bus.illegal,     32'd0);
        chk("rst func3",    bus.func3,       32'd0);
        chk("rst func7",    bus.func7,       32'd0);
        chk("rst rs1",      bus.rs1_data,    32'd0);
        chk("rst rs2",      bus.rs2_data,    32'd0);
        chk("rst wb_addr",  bus.wb_addr,     32'd0);
        chk("rst wb_data",  bus.wb_data,     32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst ready", bus.instr_ready, 32'd1);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = i[4:0];
            @(negedge clk);
            chk($sformatf("rst dbg x%0d", i), dbg_data, 32'd0);
        end
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            run_instr(vecs[i].name, vecs[i].ins, vecs[i].legal, vecs[i].f3,
                      vecs[i].f7, vecs[i].b, vecs[i].res);
        end
        dbg_addr = 5'd0;
        #1;
        chk("x0 stays zero", dbg_data, 32'd0);

        // Random instructions against the reference model
        for (int i = 0; i < 80; i++) begin
            r    = $urandom;
            kind = $urandom_range(0, 4);
            case (kind)
                0: begin
                    ins = {7'h00, r[24:7], 7'h33};
                    if (r[0] && (r[14:12] == 3'd0 || r[14:12] == 3'd5)) ins[31:25] = 7'h20;
                end
                1: begin
                    ins = {r[31:7], 7'h13};
                    if (r[14:12] == 3'd1 && r[1]) ins[31:25] = 7'h00;
                    if (r[14:12] == 3'd5 && r[1]) ins[31:25] = r[2] ? 7'h20 : 7'h00;
                end
                2: ins = r;
                3: ins = {r[31:7], 7'h33};
                default: ins = {r[31:7], 7'h13};
            endcase
            ref_model(ins, m_legal, m_f3, m_f7, m_b, m_res);
            run_instr($sformatf("rand%0d", i), ins, m_legal, m_f3, m_f7, m_b, m_res);
        end

        // Back-to-back ADDIs with instr_valid held high
        seq[0] = 32'h00500213;
        seq[1] = 32'h00620213;
        seq[2] = 32'hFFF20213;
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.instr = seq[k];
            n = 0;
            while (bus.instr_ready !== 1'b1 && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 10) chk("b2b ready timeout", 32'(n), 32'd0);
            @(posedge clk); #1;
            acc[k] = cyc;
        end
        bus.instr_valid = 1'b0;
        chk("b2b gap01", 32'(acc[1] - acc[0]), 32'd3);
        chk("b2b gap12", 32'(acc[2] - acc[1]), 32'd3);
        @(posedge clk); #1;
        chk("b2b wb_valid", bus.wb_valid, 32'd1);
        chk("b2b wb_data",  bus.wb_data,  32'd10);
        shadow[4] = 32'd10;
        @(posedge clk); #1;
        dbg_addr = 5'd4;
        #1;
        chk("b2b x4", dbg_data, 32'd10);

        // Reset in the EXEC cycle drops the instruction
        chk("rexec ready", bus.instr_ready, 32'd1);
        bus.instr       = 32'h00900293;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        chk("rexec in_exec", bus.instr_ready, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rexec wb0",    bus.wb_valid,    32'd0);
        chk("rexec rdy_rst", bus.instr_ready, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
        @(posedge clk); #1;
        chk("rexec wb1",    bus.wb_valid,    32'd0);
        chk("rexec ready_after", bus.instr_ready, 32'd1);
        dbg_addr = 5'd5;
        #1;
        chk("rexec x5", dbg_data, 32'd0);
        dbg_addr = 5'd4;
        #1;
        chk("rexec x4 cleared", dbg_data, 32'd0);
        @(posedge clk); #1;
        chk("rexec wb2", bus.wb_valid, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
